// File: rtl/bp_be_pkg.sv
// Backend types shared by the MMU load/store path: command/response structs, op encoding,
// LSU state encoding and the op -> access-size decode.
package bp_be_pkg;

    localparam int unsigned rv64_eaddr_width_gp    = 64;
    localparam int unsigned rv64_reg_data_width_gp = 64;

    // Low two bits of a memory op encode log2(bytes); bit 3 marks stores, bit 2 unsigned loads.
    typedef enum logic [3:0] {
        e_lb  = 4'b0000,
        e_lh  = 4'b0001,
        e_lw  = 4'b0010,
        e_ld  = 4'b0011,
        e_lbu = 4'b0100,
        e_lhu = 4'b0101,
        e_lwu = 4'b0110,
        e_sb  = 4'b1000,
        e_sh  = 4'b1001,
        e_sw  = 4'b1010,
        e_sd  = 4'b1011
    } bp_be_fu_op_e;

    typedef enum logic [1:0] {
        e_idle,
        e_req,
        e_wait,
        e_resp
    } bp_be_lsu_state_e;

    typedef struct packed {
        logic load_misaligned;
        logic store_misaligned;
    } bp_be_exception_s;

    typedef struct packed {
        bp_be_fu_op_e                      mem_op;
        logic [rv64_eaddr_width_gp-1:0]    vaddr;
        logic [rv64_reg_data_width_gp-1:0] data;
    } bp_be_mmu_cmd_s;

    typedef struct packed {
        bp_be_exception_s                  exception;
        logic [rv64_reg_data_width_gp-1:0] data;
    } bp_be_mmu_resp_s;

    typedef struct packed {
        logic       w;
        logic [1:0] size;
        logic       sext;
    } bp_be_lsu_decode_s;

    // Anything that is not a memory op behaves as LD.
    function automatic bp_be_lsu_decode_s bp_be_lsu_decode(bp_be_fu_op_e op);
        bp_be_lsu_decode_s dec;
        dec = '{w: 1'b0, size: 2'd3, sext: 1'b1};
        case (op)
            e_lb:    dec = '{w: 1'b0, size: 2'd0, sext: 1'b1};
            e_lh:    dec = '{w: 1'b0, size: 2'd1, sext: 1'b1};
            e_lw:    dec = '{w: 1'b0, size: 2'd2, sext: 1'b1};
            e_lbu:   dec = '{w: 1'b0, size: 2'd0, sext: 1'b0};
            e_lhu:   dec = '{w: 1'b0, size: 2'd1, sext: 1'b0};
            e_lwu:   dec = '{w: 1'b0, size: 2'd2, sext: 1'b0};
            e_sb:    dec = '{w: 1'b1, size: 2'd0, sext: 1'b0};
            e_sh:    dec = '{w: 1'b1, size: 2'd1, sext: 1'b0};
            e_sw:    dec = '{w: 1'b1, size: 2'd2, sext: 1'b0};
            e_sd:    dec = '{w: 1'b1, size: 2'd3, sext: 1'b0};
            default: dec = '{w: 1'b0, size: 2'd3, sext: 1'b1};
        endcase
        return dec;
    endfunction

    // Byte-offset bits that must be zero for an access of the given size.
    function automatic logic [2:0] bp_be_size_mask(logic [1:0] size);
        logic [2:0] mask;
        mask = 3'b111;
        case (size)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bp_be_lsu_extend.sv
// Combinational sign/zero extension of right-justified load data by access size.
module bp_be_lsu_extend #(
    parameter int unsigned data_width_p = 64
) (
    input  logic [1:0]              size_i,
    input  logic                    sext_i,
    input  logic [data_width_p-1:0] data_i,
    output logic [data_width_p-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        unique case (size_i)
            2'd0: data_o = {{(data_width_p-8){sext_i & data_i[7]}}, data_i[7:0]};
            2'd1: data_o = {{(data_width_p-16){sext_i & data_i[15]}}, data_i[15:0]};
            2'd2: data_o = {{(data_width_p-32){sext_i & data_i[31]}}, data_i[31:0]};
            2'd3: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/bp_be_mmu_lsu.sv
// Load/store unit behind the backend MMU command port: one op in flight, one aligned memory
// request per op. Define BP_BE_MMU_LSU_MISALIGN_CHECK_EN to trap misaligned accesses.
module bp_be_mmu_lsu
    import bp_be_pkg::*;
#(
    parameter int unsigned eaddr_width_p = rv64_eaddr_width_gp,
    parameter int unsigned data_width_p  = rv64_reg_data_width_gp
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  bp_be_mmu_cmd_s           mmu_cmd_i,
    input  logic                     mmu_cmd_v_i,
    output logic                     mmu_cmd_ready_o,
    output bp_be_mmu_resp_s          mmu_resp_o,
    output logic                     mmu_resp_v_o,
    input  logic                     mmu_resp_ready_i,
    output logic                     mem_req_v_o,
    input  logic                     mem_req_ready_i,
    output logic                     mem_req_w_o,
    output logic [1:0]               mem_req_size_o,
    output logic [eaddr_width_p-1:0] mem_req_addr_o,
    output logic [data_width_p-1:0]  mem_req_data_o,
    input  logic                     mem_resp_v_i,
    input  logic [data_width_p-1:0]  mem_resp_data_i
);

    bp_be_lsu_state_e                  state_q, state_d;
    bp_be_mmu_cmd_s                    cmd_q, cmd_d;
    logic [rv64_reg_data_width_gp-1:0] data_q, data_d;
    bp_be_exception_s                  exc_q, exc_d;
    bp_be_lsu_decode_s                 dec_q;
    logic [data_width_p-1:0]           ext_data;
    logic [rv64_reg_data_width_gp-1:0] store_data;
    logic [rv64_eaddr_width_gp-1:0]    addr_aligned;

`ifdef BP_BE_MMU_LSU_MISALIGN_CHECK_EN
    bp_be_lsu_decode_s dec_in;
    logic              misaligned_in;

    assign dec_in        = bp_be_lsu_decode(mmu_cmd_i.mem_op);
    assign misaligned_in = |(mmu_cmd_i.vaddr[2:0] & bp_be_size_mask(dec_in.size));
`endif

    assign dec_q = bp_be_lsu_decode(cmd_q.mem_op);

    bp_be_lsu_extend #(
        .data_width_p(data_width_p)
    ) extend (
        .size_i(dec_q.size),
        .sext_i(dec_q.sext),
        .data_i(mem_resp_data_i),
        .data_o(ext_data)
    );

    always_comb begin
        store_data = cmd_q.data;
        unique case (dec_q.size)
            2'd0: store_data = {56'b0, cmd_q.data[7:0]};
            2'd1: store_data = {48'b0, cmd_q.data[15:0]};
            2'd2: store_data = {32'b0, cmd_q.data[31:0]};
            2'd3: store_data = cmd_q.data;
        endcase
    end

    // Low offset bits are dropped rather than trapped when the misalign check is absent.
    assign addr_aligned = cmd_q.vaddr
                          & ~{{(rv64_eaddr_width_gp-3){1'b0}}, bp_be_size_mask(dec_q.size)};

    assign mem_req_w_o    = dec_q.w;
    assign mem_req_size_o = dec_q.size;
    assign mem_req_addr_o = eaddr_width_p'(addr_aligned);
    assign mem_req_data_o = data_width_p'(store_data);
    assign mmu_resp_o     = '{exception: exc_q, data: data_q};

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        data_d          = data_q;
        exc_d           = exc_q;
        mmu_cmd_ready_o = 1'b0;
        mem_req_v_o     = 1'b0;
        mmu_resp_v_o    = 1'b0;
        unique case (state_q)
            e_idle: begin
                mmu_cmd_ready_o = 1'b1;
                if (mmu_cmd_v_i) begin
                    cmd_d   = mmu_cmd_i;
                    data_d  = '0;
                    exc_d   = '0;
                    state_d = e_req;
`ifdef BP_BE_MMU_LSU_MISALIGN_CHECK_EN
                    if (misaligned_in) begin
                        exc_d.load_misaligned  = ~dec_in.w;
                        exc_d.store_misaligned = dec_in.w;
                        state_d                = e_resp;
                    end
`endif
                end
            end
            e_req: begin
                mem_req_v_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_d = e_wait;
                end
            end
            e_wait: begin
                if (mem_resp_v_i) begin
                    data_d  = dec_q.w ? '0 : rv64_reg_data_width_gp'(ext_data);
                    state_d = e_resp;
                end
            end
            e_resp: begin
                mmu_resp_v_o = 1'b1;
                if (mmu_resp_ready_i) begin
                    state_d = e_idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            cmd_q   <= '0;
            data_q  <= '0;
            exc_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
        end
    end

endmodule

// File: tb/tb_bp_be_mmu_lsu.sv
// Randomized self-checking bench for bp_be_mmu_lsu against an arithmetic load/store model.
`timescale 1ns/1ps
module tb_bp_be_mmu_lsu;
    import bp_be_pkg::*;

    logic            clk = 1'b0;
    logic            reset_i;
    bp_be_mmu_cmd_s  mmu_cmd_i;
    logic            mmu_cmd_v_i;
    logic            mmu_cmd_ready_o;
    bp_be_mmu_resp_s mmu_resp_o;
    logic            mmu_resp_v_o;
    logic            mmu_resp_ready_i;
    logic            mem_req_v_o;
    logic            mem_req_ready_i;
    logic            mem_req_w_o;
    logic [1:0]      mem_req_size_o;
    logic [63:0]     mem_req_addr_o;
    logic [63:0]     mem_req_data_o;
    logic            mem_resp_v_i;
    logic [63:0]     mem_resp_data_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bp_be_mmu_lsu dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .mmu_cmd_i       (mmu_cmd_i),
        .mmu_cmd_v_i     (mmu_cmd_v_i),
        .mmu_cmd_ready_o (mmu_cmd_ready_o),
        .mmu_resp_o      (mmu_resp_o),
        .mmu_resp_v_o    (mmu_resp_v_o),
        .mmu_resp_ready_i(mmu_resp_ready_i),
        .mem_req_v_o     (mem_req_v_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_w_o     (mem_req_w_o),
        .mem_req_size_o  (mem_req_size_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_data_o  (mem_req_data_o),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_data_i (mem_resp_data_i)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            e_lb, e_lbu, e_sb: return 1;
            e_lh, e_lhu, e_sh: return 2;
            e_lw, e_lwu, e_sw: return 4;
            default:           return 8;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return (op == e_sb) || (op == e_sh) || (op == e_sw) || (op == e_sd);
    endfunction

    function automatic bit op_is_unsigned(input logic [3:0] op);
        return (op == e_lbu) || (op == e_lhu) || (op == e_lwu);
    endfunction

    function automatic logic [63:0] low_part(input logic [63:0] v, input int nbytes);
        if (nbytes >= 8) return v;
        return v % (64'd1 << (8 * nbytes));
    endfunction

    function automatic logic [63:0] model_load(input logic [3:0] op, input logic [63:0] mem);
        int          n;
        logic [63:0] u;
        n = op_bytes(op);
        u = low_part(mem, n);
        if (!op_is_unsigned(op) && n < 8 && u >= (64'd1 << (8 * n - 1)))
            u = u - (64'd1 << (8 * n));
        return u;
    endfunction

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] mdata, input int req_stall, input int resp_stall,
                          input int wait_dly);
        bit          st;
        bit          mis;
        int          n;
        logic [63:0] exp_data;
        st  = op_is_store(op);
        n   = op_bytes(op);
        mis = 1'b0;
`ifdef BP_BE_MMU_LSU_MISALIGN_CHECK_EN
        mis = (addr % n) != 0;
`endif
        exp_data = (st || mis) ? 64'd0 : model_load(op, mdata);

        check_val("cmd_ready_idle", mmu_cmd_ready_o, 1);
        mmu_cmd_i   = '{mem_op: bp_be_fu_op_e'(op), vaddr: addr, data: sdata};
        mmu_cmd_v_i = 1'b1;
        idle_cycle();
        mmu_cmd_v_i = 1'b0;
        mmu_cmd_i   = '{mem_op: e_lb, vaddr: {$urandom, $urandom}, data: {$urandom, $urandom}};

        if (!mis) begin
            for (int c = 0; c <= req_stall; c++) begin
                mem_req_ready_i = (c == req_stall);
                check_val("req_v", mem_req_v_o, 1);
                check_val("req_w", mem_req_w_o, st);
                check_val("req_size", mem_req_size_o, 64'($clog2(n)));
                check_val("req_addr", mem_req_addr_o, addr - (addr % n));
                if (st) check_val("req_data", mem_req_data_o, low_part(sdata, n));
                check_val("cmd_ready_busy", mmu_cmd_ready_o, 0);
                check_val("resp_v_early", mmu_resp_v_o, 0);
                idle_cycle();
            end
            mem_req_ready_i = 1'b0;
            for (int c = 0; c <= wait_dly; c++) begin
                check_val("req_v_single", mem_req_v_o, 0);
                check_val("resp_v_wait", mmu_resp_v_o, 0);
                if (c < wait_dly) idle_cycle();
            end
            mem_resp_v_i    = 1'b1;
            mem_resp_data_i = mdata;
            idle_cycle();
            mem_resp_v_i    = 1'b0;
            mem_resp_data_i = {$urandom, $urandom};
        end

        for (int c = 0; c <= resp_stall; c++) begin
            mmu_resp_ready_i = (c == resp_stall);
            check_val("resp_v", mmu_resp_v_o, 1);
            check_val("resp_data", mmu_resp_o.data, exp_data);
            check_val("exc_load_mis", mmu_resp_o.exception.load_misaligned, mis && !st);
            check_val("exc_store_mis", mmu_resp_o.exception.store_misaligned, mis && st);
            check_val("req_v_in_resp", mem_req_v_o, 0);
            check_val("cmd_ready_resp", mmu_cmd_ready_o, 0);
            idle_cycle();
        end
        mmu_resp_ready_i = 1'b0;
        check_val("resp_v_done", mmu_resp_v_o, 0);
    endtask

    initial begin
        logic [3:0] op;
        logic [63:0] addr;
        reset_i          = 1'b1;
        mmu_cmd_i        = '0;
        mmu_cmd_v_i      = 1'b0;
        mmu_resp_ready_i = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_v_i     = 1'b0;
        mem_resp_data_i  = '0;
        #1;
        check_val("rst_cmd_ready", mmu_cmd_ready_o, 1);
        check_val("rst_resp_v", mmu_resp_v_o, 0);
        check_val("rst_req_v", mem_req_v_o, 0);
        check_val("rst_resp", 64'(mmu_resp_o), 0);
        idle_cycle();
        reset_i = 1'b0;
        idle_cycle();

        // Reset while waiting on memory drops the op.
        mmu_cmd_i       = '{mem_op: e_ld, vaddr: 64'h40, data: 64'h0};
        mmu_cmd_v_i     = 1'b1;
        mem_req_ready_i = 1'b1;
        idle_cycle();
        mmu_cmd_v_i = 1'b0;
        idle_cycle();
        mem_req_ready_i = 1'b0;
        check_val("wait_cmd_ready", mmu_cmd_ready_o, 0);
        reset_i = 1'b1;
        #1;
        check_val("arst_cmd_ready", mmu_cmd_ready_o, 1);
        check_val("arst_req_v", mem_req_v_o, 0);
        idle_cycle();
        reset_i = 1'b0;
        idle_cycle();
        check_val("post_rst_cmd_ready", mmu_cmd_ready_o, 1);
        check_val("post_rst_resp_v", mmu_resp_v_o, 0);
        check_val("post_rst_req_v", mem_req_v_o, 0);
        check_val("post_rst_resp", 64'(mmu_resp_o), 0);

        // Directed cases.
        run_op(e_lb, 64'h8000_0003, 64'h0, 64'h80, 0, 0, 0);
        run_op(e_lwu, 64'h8000_0004, 64'h0, 64'hDEAD_BEEF, 0, 0, 0);
        run_op(e_sh, 64'h10, 64'h1234_5678, 64'hFFFF_FFFF, 0, 0, 0);
        run_op(e_lw, 64'h2000, 64'h0, 64'h8765_4321, 4, 3, 0);
        run_op(e_ld, 64'h1004, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 0);
        run_op(4'b0111, 64'h3000, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 0, 1);

        // Stray memory responses while idle must not produce anything.
        mem_resp_v_i    = 1'b1;
        mem_resp_data_i = 64'hBAD;
        idle_cycle();
        mem_resp_v_i = 1'b0;
        check_val("stray_resp_v", mmu_resp_v_o, 0);
        check_val("stray_cmd_ready", mmu_cmd_ready_o, 1);

        for (int i = 0; i < 80; i++) begin
            op   = 4'($urandom_range(0, 15));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) addr[2:0] = 3'b000;
            run_op(op, addr, {$urandom, $urandom}, {$urandom, $urandom},
                   ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                   ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
